booth_mac_acc: RTL and testbench
================================

# booth_mac_acc

Downstream consumer of the radix-4 Booth multiplier: accepts signed 2N-bit products over a valid/ready handshake and accumulates them into a wider signed accumulator over a programmable number of terms (dot-product length). When the final term arrives, it presents the sum on a held valid/ready output. Sits between the multiplier result register and the dot-product/filter control logic.

## Interface
- N, 16, multiplier operand width; product width is 2N
- ACC_W, 40, accumulator width; ACC_W ≥ 2N
- LEN_W, 8, width of the term-count input
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- clear  input  1  synchronous flush of the vector in progress and any pending result
- len_cfg  input  LEN_W  number of terms per vector; sampled on the first accepted term; 0 is treated as 1
- in_valid  input  1  in_prod is valid
- in_ready  output  1  block accepts in_prod this cycle
- in_prod  input  2N  signed product from the multiplier
- out_valid  output  1  out_acc/out_ovf are valid
- out_ready  input  1  consumer takes the result
- out_acc  output  ACC_W  signed vector sum
- out_ovf  output  1  at least one signed overflow occurred in this vector

## Operation
- States: IDLE (no terms yet), ACCUM (≥1 term taken, more due), HOLD (result presented).
- in_ready = 1 in IDLE/ACCUM and 0 in HOLD; it is also 0 while reset or clear is high.
- Accept = in_valid & in_ready.
- IDLE, accept: acc ← sext(in_prod); remaining ← max(len_cfg,1)−1; ovf ← 0. Go to HOLD if remaining = 0, else to ACCUM.
- ACCUM, accept: acc ← acc + sext(in_prod); remaining decrements. Go to HOLD when the term taken was the last one.
- HOLD: out_valid = 1. out_acc and out_ovf are stable. On out_valid & out_ready, go to IDLE and clear acc to 0 on the following edge. No input is accepted in the cycle of the output handshake.
- Arithmetic:
  - in_prod is sign-extended to ACC_W+1 bits.
  - Overflow occurs when the (ACC_W+1)-bit sum differs from the sign-extension of its ACC_W-bit truncation.
  - Overflow sets sticky ovf for the vector.
- len_cfg changes mid-vector are ignored.
- Priority: reset > clear > normal operation.
- Reset or clear, from any state: state goes to IDLE; acc, remaining, ovf, out_valid all go to 0. A partial vector is discarded without output.

## Timing
- Reset values: out_valid = 0, out_acc = 0, out_ovf = 0, in_ready = 0 while reset is high and 1 in the cycle after release.
- Latency: out_valid rises on the clock edge that accepts the last term and is visible in the next cycle.
- Throughput: one term per cycle in IDLE/ACCUM. Minimum vector period is len + 1 cycles, since the HOLD handshake takes one cycle.
- out_valid stays high until the out_ready handshake. It deasserts the cycle after the handshake; in_ready reasserts in that same cycle.
- in_valid low mid-vector: the block stays in ACCUM indefinitely.

## Configuration
- BOOTH_MAC_SAT_EN defined: on overflow, acc saturates to +(2^(ACC_W−1)−1) or −2^(ACC_W−1), following the sign of the true sum. Later terms add to the saturated value. out_ovf is still set.
- BOOTH_MAC_SAT_EN undefined: acc wraps modulo 2^ACC_W; out_ovf is set.

## Test plan
- len_cfg = 4; products 6, −2, 100, −50 on consecutive cycles -> out_valid high one cycle after the 4th accept; out_acc = 54; out_ovf = 0.
- As above with out_ready = 0 for 5 cycles -> out_valid, out_acc = 54, in_ready = 0 all held; out_ready = 1 -> out_valid = 0 and in_ready = 1 the next cycle.
- len_cfg = 0; single product 1073676289 (32767×32767) -> out_acc = 1073676289 one cycle later.
- ACC_W = 32; len_cfg = 2; products 1073741824 twice -> without the macro: out_acc = −2147483648, out_ovf = 1. With BOOTH_MAC_SAT_EN: out_acc = 2147483647, out_ovf = 1.
- len_cfg = 4; two products 10 and 20, then clear pulse -> no out_valid. Next vector with len_cfg = 1 and product 7 -> out_acc = 7, out_ovf = 0.
- Reset asserted while in HOLD with out_acc = 54 -> next cycle out_valid = 0, out_acc = 0, out_ovf = 0; in_ready = 1 after reset release.

Source files
------------

// File: rtl/booth_mac_acc_if.sv
// booth_mac_acc_if: product input channel and result output channel of the
// Booth MAC accumulator, grouped as one valid/ready bundle.
//   slave  - accumulator side (takes products, presents results)
//   master - producer/consumer side (drives products, takes results)
interface booth_mac_acc_if #(
  parameter int N     = 16,
  parameter int ACC_W = 40
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*N-1:0]       in_prod;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_acc;
  logic                 out_ovf;

  modport slave (
    input  in_valid,
    input  in_prod,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_acc,
    output out_ovf
  );

  modport master (
    output in_valid,
    output in_prod,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_acc,
    input  out_ovf
  );
endinterface

// File: rtl/booth_mac_acc.sv
// booth_mac_acc: accumulates signed 2N-bit Booth products into a signed
// ACC_W-bit sum over len_cfg terms and presents the result on a held
// valid/ready output.
// Optional feature macro: BOOTH_MAC_SAT_EN
//   defined   - accumulator saturates on signed overflow
//   undefined - accumulator wraps modulo 2^ACC_W
// In both builds out_ovf flags any overflow within the vector.
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no term of the current vector taken yet
// ACCUM | at least one term taken, more terms due
// HOLD  | vector complete, result presented on out_*
module booth_mac_acc #(
  parameter int N     = 16,
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [LEN_W-1:0] len_cfg,
  booth_mac_acc_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nx;

  logic signed [ACC_W-1:0] acc;
  logic [LEN_W-1:0]        remaining;
  logic                    ovf;

  logic                    flush;
  logic                    accept;
  logic                    last_term;
  logic [LEN_W-1:0]        len_m1;

  logic signed [ACC_W-1:0] prod_res;
  logic signed [ACC_W:0]   prod_ext;
  logic signed [ACC_W:0]   acc_ext;
  logic signed [ACC_W:0]   sum;
  logic                    sum_ovf;
  logic signed [ACC_W-1:0] sum_res;

  localparam logic signed [ACC_W-1:0] SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  // Handshake qualification; reset and clear both block new terms.
  assign flush        = reset | clear;
  assign bus.in_ready = (state != HOLD) & ~flush;
  assign accept       = bus.in_valid & bus.in_ready;

  // A programmed length of zero behaves as a single-term vector.
  assign len_m1    = (len_cfg == '0) ? '0 : len_cfg - LEN_W'(1);
  assign last_term = (state == IDLE) ? (len_m1 == '0) : (remaining == LEN_W'(1));

  // Sign-extended add with one guard bit for overflow detection.
  assign prod_res = ACC_W'($signed(bus.in_prod));
  assign prod_ext = {prod_res[ACC_W-1], prod_res};
  assign acc_ext  = {acc[ACC_W-1], acc};
  assign sum      = acc_ext + prod_ext;
  assign sum_ovf  = sum[ACC_W] != sum[ACC_W-1];

`ifdef BOOTH_MAC_SAT_EN
  // Clamp toward the sign of the true (guard-bit) sum.
  assign sum_res = sum_ovf ? (sum[ACC_W] ? SAT_NEG : SAT_POS) : sum[ACC_W-1:0];
`else
  // Plain two's-complement wrap; out_ovf still records the event.
  assign sum_res = sum[ACC_W-1:0];
`endif

  // Output bundle: result is the accumulator itself, valid only in HOLD.
  assign bus.out_valid = (state == HOLD);
  assign bus.out_acc   = acc;
  assign bus.out_ovf   = ovf;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = last_term ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (accept && last_term) state_nx = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Accumulator, term down-counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc       <= prod_res;
            remaining <= len_m1;
            ovf       <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc       <= sum_res;
            remaining <= remaining - LEN_W'(1);
            ovf       <= ovf | sum_ovf;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc <= '0;
            ovf <= 1'b0;
          end
        end
        default: begin
          acc       <= '0;
          remaining <= '0;
          ovf       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_acc.sv
// tb_booth_mac_acc: randomized and directed bench for booth_mac_acc against
// an integer-arithmetic model of the vector sum (wrap or saturate follows
// BOOTH_MAC_SAT_EN). Built with ACC_W = 32 so overflow is reachable.
module tb_booth_mac_acc;
  localparam int N     = 16;
  localparam int ACC_W = 32;
  localparam int LEN_W = 8;

  logic             clk     = 1'b0;
  logic             reset   = 1'b1;
  logic             clear   = 1'b0;
  logic [LEN_W-1:0] len_cfg = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_mac_acc_if #(.N(N), .ACC_W(ACC_W)) bus ();

  booth_mac_acc #(.N(N), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .len_cfg (len_cfg),
    .bus     (bus)
  );

  // Reference: exact integer sum, clamped or wrapped to ACC_W bits per term.
  function automatic void model(input longint prods[$], output longint exp_acc,
                                output bit exp_ovf);
    longint maxv = (longint'(1) <<< (ACC_W-1)) - 1;
    longint minv = -(longint'(1) <<< (ACC_W-1));
    longint modv = longint'(1) <<< ACC_W;
    longint s    = prods[0];
    exp_ovf = 1'b0;
    for (int i = 1; i < prods.size(); i++) begin
      s = s + prods[i];
      if (s > maxv || s < minv) begin
        exp_ovf = 1'b1;
`ifdef BOOTH_MAC_SAT_EN
        s = (s > maxv) ? maxv : minv;
`else
        s = ((s % modv) + modv) % modv;
        if (s > maxv) s = s - modv;
`endif
      end
    end
    exp_acc = s;
  endfunction

  // Present one term and wait (bounded) until it is accepted.
  task automatic send_term(input longint p);
    int waitc = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = 32'(p);
    #1;
    while (!bus.in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_out_ready();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_acc !== '0) begin n_fail++; $display("FAIL reset_out_acc: got %0d want 0", $signed(bus.out_acc)); end
    n_checks++; if (bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b want 0", bus.out_ovf); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic_hold();
    longint q[$] = '{6, -2, 100, -50};
    longint e; bit eo;
    model(q, e, eo);
    len_cfg = 8'd4;
    for (int i = 0; i < 3; i++) send_term(q[i]);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); end
    send_term(q[3]);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (longint'($signed(bus.out_acc)) !== e) begin n_fail++; $display("FAIL basic_acc: got %0d want %0d", $signed(bus.out_acc), e); end
    n_checks++; if (bus.out_ovf !== eo) begin n_fail++; $display("FAIL basic_ovf: got %b want %b", bus.out_ovf, eo); end
    // Offer a stray term during HOLD; it must not be taken.
    bus.in_valid = 1'b1;
    bus.in_prod  = 32'd999;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b want 1", bus.out_valid); end
      n_checks++; if (longint'($signed(bus.out_acc)) !== e) begin n_fail++; $display("FAIL hold_acc: got %0d want %0d", $signed(bus.out_acc), e); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b want 0", bus.in_ready); end
    end
    pulse_out_ready();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hs_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hs_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_acc !== '0) begin n_fail++; $display("FAIL hs_acc_cleared: got %0d want 0", $signed(bus.out_acc)); end
  endtask

  task automatic test_len_zero();
    longint p = longint'(32767) * longint'(32767);
    len_cfg = 8'd0;
    send_term(p);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL len0_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (longint'($signed(bus.out_acc)) !== p) begin n_fail++; $display("FAIL len0_acc: got %0d want %0d", $signed(bus.out_acc), p); end
    pulse_out_ready();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL len0_hs_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    longint q[$] = '{1073741824, 1073741824};
    longint e; bit eo;
    model(q, e, eo);
    len_cfg = 8'd2;
    send_term(q[0]);
    send_term(q[1]);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (longint'($signed(bus.out_acc)) !== e) begin n_fail++; $display("FAIL ovf_acc: got %0d want %0d", $signed(bus.out_acc), e); end
    n_checks++; if (bus.out_ovf !== eo) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", bus.out_ovf, eo); end
    pulse_out_ready();
  endtask

  task automatic test_clear();
    len_cfg = 8'd4;
    send_term(10);
    send_term(20);
    clear = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready: got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    clear = 1'b0;
    n_checks++; if (bus.out_acc !== '0) begin n_fail++; $display("FAIL clear_acc: got %0d want 0", $signed(bus.out_acc)); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_no_valid: got %b want 0", bus.out_valid); end
    end
    len_cfg = 8'd1;
    send_term(7);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_next_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (longint'($signed(bus.out_acc)) !== 64'sd7) begin n_fail++; $display("FAIL clear_next_acc: got %0d want 7", $signed(bus.out_acc)); end
    n_checks++; if (bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL clear_next_ovf: got %b want 0", bus.out_ovf); end
    pulse_out_ready();
  endtask

  task automatic test_reset_in_hold();
    longint q[$] = '{6, -2, 100, -50};
    longint e; bit eo;
    model(q, e, eo);
    len_cfg = 8'd4;
    foreach (q[i]) send_term(q[i]);
    n_checks++; if (longint'($signed(bus.out_acc)) !== e) begin n_fail++; $display("FAIL rsthold_acc_before: got %0d want %0d", $signed(bus.out_acc), e); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_acc !== '0) begin n_fail++; $display("FAIL rsthold_acc: got %0d want 0", $signed(bus.out_acc)); end
    n_checks++; if (bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL rsthold_ovf: got %b want 0", bus.out_ovf); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rsthold_in_ready: got %b want 0", bus.in_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rsthold_release: got %b want 1", bus.in_ready); end
  endtask

  // Random vectors: random lengths, operand values, input gaps, output stalls
  // and mid-vector len_cfg changes; vectors start right after each handshake.
  task automatic test_random();
    for (int v = 0; v < 30; v++) begin
      longint q[$];
      longint e; bit eo;
      int len = $urandom_range(0, 6);
      int nterm = (len == 0) ? 1 : len;
      for (int t = 0; t < nterm; t++) begin
        shortint a = shortint'($urandom_range(0, 65535));
        shortint b = shortint'($urandom_range(0, 65535));
        q.push_back(longint'(a) * longint'(b));
      end
      model(q, e, eo);
      len_cfg = LEN_W'(len);
      for (int t = 0; t < nterm; t++) begin
        send_term(q[t]);
        if (t == 0) len_cfg = LEN_W'($urandom_range(0, 255));
        if (t != nterm - 1) begin
          n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_early_valid: vec %0d term %0d got %b want 0", v, t, bus.out_valid); end
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_gap_in_ready: vec %0d got %b want 1", v, bus.in_ready); end
          end
        end
      end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_valid: vec %0d got %b want 1", v, bus.out_valid); end
      n_checks++; if (longint'($signed(bus.out_acc)) !== e) begin n_fail++; $display("FAIL rnd_acc: vec %0d got %0d want %0d", v, $signed(bus.out_acc), e); end
      n_checks++; if (bus.out_ovf !== eo) begin n_fail++; $display("FAIL rnd_ovf: vec %0d got %b want %b", v, bus.out_ovf, eo); end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        n_checks++; if (longint'($signed(bus.out_acc)) !== e || bus.out_valid !== 1'b1) begin
          n_fail++; $display("FAIL rnd_hold: vec %0d acc %0d valid %b want %0d valid 1", v, $signed(bus.out_acc), bus.out_valid, e);
        end
      end
      pulse_out_ready();
      n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL rnd_handshake: vec %0d valid %b in_ready %b want 0/1", v, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_hold();
    test_len_zero();
    test_overflow();
    test_clear();
    test_reset_in_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
